// File: rtl/ser_word_collector.sv
// ser_word_collector: gathers the detector's qualified serial stream
// MSB-first into WIDTH-bit words, flags truncated bursts, counts words.
module ser_word_collector #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clk_en,
  input  logic             ser_in,
  input  logic             ser_in_valid,
  output logic [WIDTH-1:0] par_out,
  output logic             par_valid,
  output logic             frame_err,
  output logic             busy,
  output logic [3:0]       word_cnt
);

  typedef enum logic {IDLE, SHIFT} state_t;

  localparam logic [4:0] LAST = 5'(WIDTH - 1);

  state_t           state, state_n;
  logic [WIDTH-1:0] sr, sr_n, par_n;
  logic [WIDTH-1:0] shifted;
  logic [4:0]       cnt, cnt_n;
  logic [3:0]       wc_n;
  logic             pv_n, fe_n;

  assign shifted = {sr[WIDTH-2:0], ser_in};
  assign busy    = (state == SHIFT);

  // bit_cnt is always 0 in IDLE, so IDLE and SHIFT share the shift path
  always_comb begin
    state_n = state;
    sr_n    = sr;
    cnt_n   = cnt;
    par_n   = par_out;
    wc_n    = word_cnt;
    pv_n    = 1'b0;
    fe_n    = 1'b0;
    if (clk_en) begin
      if (ser_in_valid) begin
        state_n = SHIFT;
        sr_n    = shifted;
        if (cnt == LAST) begin
          cnt_n = '0;
          par_n = shifted;
          pv_n  = 1'b1;
          if (word_cnt != 4'd15)
            wc_n = word_cnt + 4'd1;
        end else begin
          cnt_n = cnt + 5'd1;
        end
      end else if (state == SHIFT) begin
        state_n = IDLE;
        if (cnt != '0) begin
          fe_n  = 1'b1;
          sr_n  = '0;
          cnt_n = '0;
        end
      end
    end
  end

  // strobes are registered every edge so they clear regardless of clk_en
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      sr        <= '0;
      cnt       <= '0;
      par_out   <= '0;
      word_cnt  <= '0;
      par_valid <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_n;
      sr        <= sr_n;
      cnt       <= cnt_n;
      par_out   <= par_n;
      word_cnt  <= wc_n;
      par_valid <= pv_n;
      frame_err <= fe_n;
    end
  end

endmodule

// File: tb/tb_ser_word_collector.sv
// tb_ser_word_collector: randomized stimulus, bit-list reference model,
// strobe scoreboard drained by a negedge monitor.
module tb_ser_word_collector;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         clk_en = 1'b0;
  logic         ser_in = 1'b0;
  logic         ser_in_valid = 1'b0;
  logic [W-1:0] par_out;
  logic         par_valid;
  logic         frame_err;
  logic         busy;
  logic [3:0]   word_cnt;

  ser_word_collector #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .clk_en       (clk_en),
    .ser_in       (ser_in),
    .ser_in_valid (ser_in_valid),
    .par_out      (par_out),
    .par_valid    (par_valid),
    .frame_err    (frame_err),
    .busy         (busy),
    .word_cnt     (word_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit           fe;
    logic [W-1:0] w;
  } ev_t;

  ev_t          evq[$];
  int           bits[$];
  bit           in_burst;
  int           m_cnt;
  logic [W-1:0] m_par;
  int           checks = 0;
  int           failures = 0;
  bit           mon_on = 1'b0;

  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", n, act, exp, $time);
    end
  endtask

  // Reference: a word is simply the list of valid bits taken MSB-first
  task automatic model(bit r, bit en, bit v, bit b);
    int w;
    if (r) begin
      bits.delete();
      evq.delete();
      in_burst = 1'b0;
      m_cnt    = 0;
      m_par    = '0;
    end else if (en) begin
      if (v) begin
        bits.push_back(int'(b));
        in_burst = 1'b1;
        if (bits.size() == W) begin
          w = 0;
          foreach (bits[i]) w = w * 2 + bits[i];
          m_par = w[W-1:0];
          if (m_cnt < 15) m_cnt++;
          evq.push_back('{1'b0, m_par});
          bits.delete();
        end
      end else if (in_burst) begin
        if (bits.size() != 0) evq.push_back('{1'b1, '0});
        bits.delete();
        in_burst = 1'b0;
      end
    end
  endtask

  task automatic step(bit r, bit en, bit v, bit b);
    rst          = r;
    clk_en       = en;
    ser_in_valid = v;
    ser_in       = b;
    @(posedge clk);
    model(r, en, v, b);
    #1;
  endtask

  task automatic send_word(logic [W-1:0] w, int gap);
    for (int i = W - 1; i >= 0; i--) begin
      repeat (gap) step(1'b0, 1'b0, 1'($urandom), 1'($urandom));
      step(1'b0, 1'b1, 1'b1, w[i]);
    end
  endtask

  task automatic end_burst(int gap);
    repeat (gap) step(1'b0, 1'b0, 1'($urandom), 1'($urandom));
    step(1'b0, 1'b1, 1'b0, 1'($urandom));
  endtask

  ev_t e;
  bit  epv, efe;

  always @(negedge clk) begin
    if (mon_on) begin
      epv = 1'b0;
      efe = 1'b0;
      if (evq.size() > 0) begin
        e   = evq.pop_front();
        epv = !e.fe;
        efe = e.fe;
        if (!e.fe) chk("par_out_word", 32'(par_out), 32'(e.w));
      end
      chk("par_valid", 32'(par_valid), 32'(epv));
      chk("frame_err", 32'(frame_err), 32'(efe));
      chk("par_out", 32'(par_out), 32'(m_par));
      chk("word_cnt", 32'(word_cnt), 32'(m_cnt));
      chk("busy", 32'(busy), 32'(in_burst));
    end
  end

  bit rv;

  initial begin
    step(1'b1, 1'b0, 1'b0, 1'b0);
    mon_on = 1'b1;
    step(1'b1, 1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b0);

    send_word(8'hB5, 0);
    end_burst(0);
    step(1'b0, 1'b1, 1'b0, 1'b0);

    send_word(8'hA5, 0);
    send_word(8'h3C, 0);
    end_burst(0);

    step(1'b0, 1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    end_burst(0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    send_word(8'hFF, 0);
    end_burst(0);

    send_word(8'h96, 3);
    end_burst(3);
    repeat (4) step(1'b0, 1'b0, 1'($urandom), 1'($urandom));

    repeat (17) send_word(W'($urandom), 0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, 1'($urandom));
    step(1'b1, 1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);

    rv = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      if (rv) rv = ($urandom_range(0, 9) != 0);
      else    rv = ($urandom_range(0, 3) == 0);
      step($urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0,
           rv, 1'($urandom));
    end
    repeat (3) step(1'b0, 1'b1, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ser_word_collector.md
# ser_word_collector

Serial-to-parallel collector placed directly downstream of the 110101 sequence detector. It consumes the detector's qualified serial stream (`ser_out` / `ser_out_valid`), assembles contiguous valid bits MSB-first into WIDTH-bit words, and presents each word with a one-cycle strobe. Bursts that end mid-word are flagged and their partial bits are dropped. A saturating counter reports how many words have been delivered.

## Interface
- WIDTH, 8, word size in bits (range 2..16)
- clk  input  1  system clock; all state changes on the rising edge
- rst  input  1  synchronous, active-high reset
- clk_en  input  1  enable; bit sampling and FSM advance only on edges where clk_en=1
- ser_in  input  1  serial data, driven from the detector's ser_out
- ser_in_valid  input  1  qualifies ser_in, driven from the detector's ser_out_valid
- par_out  output  WIDTH  last completed word, held until the next word completes
- par_valid  output  1  one-clk pulse when par_out is updated
- frame_err  output  1  one-clk pulse when a burst ends with a partial word
- busy  output  1  high while in SHIFT
- word_cnt  output  4  words delivered since reset, saturating at 15

## Operation
- **Reset:**
  - rst=1 at a clk edge takes effect regardless of clk_en.
  - Reset values: state=IDLE, shift register=0, bit_cnt=0, par_out=0, par_valid=0, frame_err=0, busy=0, word_cnt=0.
- **Bit order:** MSB-first. The first received bit of a word lands in par_out[WIDTH-1] and the last in par_out[0].
- **FSM states:** IDLE and SHIFT. All transitions below happen only on edges where clk_en=1.
  - IDLE, ser_in_valid=1: shift in ser_in, set bit_cnt=1, go to SHIFT. If WIDTH would be reached, apply the completion rule instead.
  - IDLE, ser_in_valid=0: stay in IDLE.
  - SHIFT, ser_in_valid=1: shift in ser_in and increment bit_cnt.
    - If this bit makes bit_cnt equal WIDTH: load par_out with the completed word, pulse par_valid, increment word_cnt (saturating), and reset bit_cnt to 0.
    - The FSM stays in SHIFT, so a back-to-back next word in the same burst continues with no gap.
  - SHIFT, ser_in_valid=0, bit_cnt=0: clean burst end; return to IDLE with no flag.
  - SHIFT, ser_in_valid=0, bit_cnt≠0: truncated burst.
    - Pulse frame_err, clear the shift register and bit_cnt, return to IDLE.
    - par_out and word_cnt are unchanged.
- **Enable gating:** on edges with clk_en=0, state, the shift register, bit_cnt, par_out and word_cnt all hold.
- **Strobe width:** par_valid and frame_err are high for exactly one clk cycle and clear on the next clk edge, independent of clk_en.
- **Saturation:** word_cnt stops at 15 and does not wrap. Only rst clears it.
- **busy:** equals (state==SHIFT).
- **Mid-word reset:** rst while in SHIFT discards the partial word. No frame_err is raised.

## Timing
- Sampling: ser_in and ser_in_valid are sampled on the enabled edge.
- Latency: par_out and par_valid are visible immediately after the enabled edge that samples the WIDTH-th bit, i.e. zero extra cycles.
- frame_err latency: asserted after the first enabled edge that samples ser_in_valid=0 with a partial word.
- Back-to-back words: in one continuous burst, consecutive par_valid pulses occur exactly WIDTH enabled edges apart.
- Simultaneous events:
  - A burst ending on the edge right after a word completes gives par_valid on one edge, then a clean return to IDLE on the next, with no frame_err.
  - rst has priority over every other event.

## Test plan
- **Single word:** after reset, clk_en=1 held, send burst 1,0,1,1,0,1,0,1 then valid=0 → par_out=8'hB5 and par_valid high for 1 cycle after the 8th edge; word_cnt=1; frame_err never asserted; busy returns to 0.
- **Back-to-back:** 16 continuous valid bits encoding 8'hA5 then 8'h3C → two par_valid pulses 8 edges apart; par_out=A5 then 3C; word_cnt=2.
- **Truncation:** 5 valid bits 1,1,0,1,0 then valid=0 → frame_err pulse 1 cycle; par_out keeps its previous value; word_cnt unchanged; next full burst 8'hFF delivers correctly.
- **clk_en gating:** clk_en=1 one cycle in four, word 8'h96 presented only on enabled edges, ser_in toggled randomly on disabled edges → par_out=8'h96, and par_valid is exactly 1 clk wide.
- **Saturation and reset:** deliver 17 words → word_cnt holds 15; then assert rst mid-word (after 3 bits) → all outputs 0 next cycle, no frame_err, state IDLE.
